fifo_wr_ctrl: RTL

//   Write-side controller of the asynchronous FIFO, in the w_clk domain.

---
 rtl/fifo_wr_ctrl_if.sv | 26 ++
 rtl/fifo_wr_ctrl.sv | 80 ++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side port bundle of the async FIFO: producer handshake, read-pointer
// input from the read domain, and the status/pointer outputs of the controller.
interface fifo_wr_ctrl_if #(
  parameter int PTR_WIDTH = 3
);
  logic                 w_inc;
  logic                 clr_ovf;
  logic [PTR_WIDTH:0]   r_ptr_gray;
  logic                 write_en;
  logic [PTR_WIDTH:0]   w_ptr;
  logic [PTR_WIDTH:0]   w_ptr_gray;
  logic                 full;
  logic                 almost_full;
  logic [PTR_WIDTH:0]   w_level;
  logic                 overflow;

  modport master (
    output w_inc, clr_ovf, r_ptr_gray,
    input  write_en, w_ptr, w_ptr_gray, full, almost_full, w_level, overflow
  );

  modport slave (
    input  w_inc, clr_ovf, r_ptr_gray,
    output write_en, w_ptr, w_ptr_gray, full, almost_full, w_level, overflow
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: write pointer (binary + Gray), read-pointer
// synchroniser, registered full/almost_full/level and sticky overflow.
module fifo_wr_ctrl #(
  parameter int PTR_WIDTH = 3,
  parameter int AF_THRESH = 6
) (
  input  logic           w_clk,
  input  logic           reset,
  fifo_wr_ctrl_if.slave  wif
);

  localparam logic [PTR_WIDTH:0] AF_LVL = (PTR_WIDTH+1)'(AF_THRESH);

  function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
    logic [PTR_WIDTH:0] b;
    b[PTR_WIDTH] = g[PTR_WIDTH];
    for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PTR_WIDTH:0] rq1;
  logic [PTR_WIDTH:0] rq2;
  logic [PTR_WIDTH:0] rbin;
  logic [PTR_WIDTH:0] wbin_nxt;
  logic [PTR_WIDTH:0] wgray_nxt;
  logic [PTR_WIDTH:0] level_nxt;
  logic [PTR_WIDTH:0] full_cmp;

  assign wif.write_en = wif.w_inc & ~wif.full;

  always_comb begin
    rbin      = gray2bin(rq2);
    wbin_nxt  = wif.w_ptr + (PTR_WIDTH+1)'(wif.write_en);
    wgray_nxt = wbin_nxt ^ (wbin_nxt >> 1);
    level_nxt = wbin_nxt - rbin;
    // Full when the write pointer sits exactly one lap ahead of the read pointer:
    // in Gray code that is the top two bits inverted, the rest equal.
    full_cmp  = {~rq2[PTR_WIDTH:PTR_WIDTH-1], rq2[PTR_WIDTH-2:0]};
  end

  always_ff @(posedge w_clk or posedge reset) begin
    if (reset) begin
      rq1 <= '0;
      rq2 <= '0;
    end else begin
      rq1 <= wif.r_ptr_gray;
      rq2 <= rq1;
    end
  end

  always_ff @(posedge w_clk or posedge reset) begin
    if (reset) begin
      wif.w_ptr       <= '0;
      wif.w_ptr_gray  <= '0;
      wif.full        <= 1'b0;
      wif.almost_full <= 1'b0;
      wif.w_level     <= '0;
    end else begin
      wif.w_ptr       <= wbin_nxt;
      wif.w_ptr_gray  <= wgray_nxt;
      wif.full        <= (wgray_nxt == full_cmp);
      wif.almost_full <= (level_nxt >= AF_LVL);
      wif.w_level     <= level_nxt;
    end
  end

  // Set has priority so a drop coinciding with a clear is never lost.
  always_ff @(posedge w_clk or posedge reset) begin
    if (reset) begin
      wif.overflow <= 1'b0;
    end else if (wif.w_inc && wif.full) begin
      wif.overflow <= 1'b1;
    end else if (wif.clr_ovf) begin
      wif.overflow <= 1'b0;
    end
  end

endmodule
